// File: rtl/vdp_run_sequencer.sv
`default_nettype none
// =============================================================================
// vdp_run_sequencer: drives one vdp_top core through an n-iteration run and
// buffers {index, x} results in a first-word-fall-through FIFO.
// Rev 1.0
// =============================================================================
module vdp_run_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_cfg_we,
    input  logic [31:0]             i_cfg_mu,
    input  logic [31:0]             i_cfg_dt,
    input  logic [31:0]             i_cfg_a,
    input  logic                    i_run,
    input  logic [15:0]             i_n_iter,
    input  logic                    i_abort,
    output logic                    o_busy,
    output logic                    o_run_done,
    output logic                    o_timeout_err,
    output logic                    o_core_start,
    output logic [31:0]             o_core_mu,
    output logic [31:0]             o_core_dt,
    output logic [31:0]             o_core_a,
    input  logic [31:0]             i_core_x,
    input  logic                    i_core_done,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [31:0]             o_out_data,
    output logic [15:0]             o_out_index,
    output logic [$clog2(DEPTH):0]  o_fifo_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_TW = $clog2(TIMEOUT + 1);
    // Timer starts at 0 on the cycle after core_start, so expiring at
    // TIMEOUT-2 makes the error flag appear exactly TIMEOUT cycles after it.
    localparam logic [c_TW-1:0] c_TLIMIT = c_TW'(TIMEOUT - 2);
    localparam logic [c_AW:0]   c_DEPTH  = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    logic [15:0]      r_n_iter;
    logic [15:0]      r_iter;
    logic [c_TW-1:0]  r_timer;
    logic             r_done_q;
    logic             r_run_done;
    logic             r_timeout_err;
    logic [31:0]      r_mu;
    logic [31:0]      r_dt;
    logic [31:0]      r_a;

    logic [47:0]      r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic             w_done_edge;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_timer_exp;
    logic             w_last;

    assign w_done_edge = i_core_done & ~r_done_q;
    assign w_full      = (r_count == c_DEPTH);
    assign w_push      = (r_state == S_WAIT) && w_done_edge && !i_abort;
    assign w_pop       = (r_count != '0) && i_out_ready;
    assign w_timer_exp = (r_timer == c_TLIMIT);
    assign w_last      = ((r_iter + 16'd1) == r_n_iter);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_n_iter      <= '0;
            r_iter        <= '0;
            r_timer       <= '0;
            r_done_q      <= 1'b0;
            r_run_done    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_mu          <= '0;
            r_dt          <= '0;
            r_a           <= '0;
        end else begin
            r_done_q   <= i_core_done;
            r_run_done <= 1'b0;

            if (r_state == S_IDLE && i_cfg_we) begin
                r_mu <= i_cfg_mu;
                r_dt <= i_cfg_dt;
                r_a  <= i_cfg_a;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_n_iter      <= i_n_iter;
                        r_iter        <= '0;
                        r_timeout_err <= 1'b0;
                        if (i_n_iter == 16'd0) begin
                            r_run_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (!w_full) begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_abort) begin
                        // A result arriving with the abort is dropped outright.
                        if (w_done_edge) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DRAIN;
                            r_timer <= '0;
                        end
                    end else if (w_done_edge) begin
                        r_iter <= r_iter + 16'd1;
                        if (w_last) begin
                            r_state    <= S_IDLE;
                            r_run_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end else if (w_timer_exp) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_done_edge) begin
                        r_state <= S_IDLE;
                    end else if (w_timer_exp) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_iter, i_core_x};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign o_busy        = (r_state != S_IDLE);
    assign o_run_done    = r_run_done;
    assign o_timeout_err = r_timeout_err;
    assign o_core_start  = (r_state == S_ISSUE) && !w_full && !i_abort;
    assign o_core_mu     = r_mu;
    assign o_core_dt     = r_dt;
    assign o_core_a      = r_a;
    assign o_out_valid   = (r_count != '0);
    assign o_out_data    = r_mem[r_rd_ptr][31:0];
    assign o_out_index   = r_mem[r_rd_ptr][47:32];
    assign o_fifo_count  = r_count;

endmodule
`default_nettype wire

// File: doc/vdp_run_sequencer.md
Name: vdp_run_sequencer

Overview:
Controller that sequences one vdp_top core through a multi-iteration run. It holds the oscillator parameters (mu, dt, a; Q16.16) stable and issues one start pulse per iteration, waiting on the core's done. Each result x is buffered with its iteration index in an output FIFO drained by a valid/ready stream. The block handles backpressure, done-timeout, and abort with drain. It sits between the host/config logic and vdp_top, replacing testbench-driven start/done sequencing.

Parameters:
DEPTH, 16, output FIFO entries (power of two, ≥2)
TIMEOUT, 1024, max cycles in WAIT/DRAIN before error (≥2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
cfg_we  in  1  load cfg_mu/cfg_dt/cfg_a (ignored while busy)
cfg_mu  in  32  Q16.16 mu
cfg_dt  in  32  Q16.16 dt
cfg_a  in  32  Q16.16 a
run  in  1  start run (sampled in IDLE only)
n_iter  in  16  iterations for run, latched with run
abort  in  1  terminate run
busy  out  1  high in any state except IDLE
run_done  out  1  1-cycle pulse, run completed normally
timeout_err  out  1  sticky, done timeout occurred
core_start  out  1  1-cycle start pulse to vdp_top
core_mu  out  32  registered params to core
core_dt  out  32
core_a  out  32
core_x  in  32  core result
core_done  in  1  core done (level)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer ready
out_data  out  32  FIFO head x
out_index  out  16  FIFO head iteration index
fifo_count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset: state IDLE; busy, run_done, timeout_err, core_start, out_valid = 0; core_mu/dt/a = 0; FIFO empty; fifo_count = 0; counters 0. Reset mid-run aborts immediately; no drain.
- Config: cfg_we && !busy loads core_* next cycle. cfg_we while busy is ignored, so params stay constant for the whole run.
- done_edge = core_done & ~done_q, where done_q is core_done registered. Only rising edges count.
- IDLE: on run, latch n_iter and clear iter_cnt and timeout_err. If n_iter == 0: pulse run_done next cycle and stay IDLE. Otherwise go ISSUE.
- ISSUE: if fifo_count < DEPTH, assert core_start combinationally for this single cycle and go WAIT with the timer cleared. Otherwise hold; no start is issued until space exists. A pushed result therefore never overflows.
- Latency: run sampled at cycle t → core_start at t+1 (FIFO not full).
- WAIT: timer increments each cycle.
  - On done_edge: push {iter_cnt, core_x} and increment iter_cnt. If iter_cnt+1 == n_iter, go IDLE and pulse run_done the following cycle. Otherwise go ISSUE.
  - If the timer reaches TIMEOUT with no edge: set timeout_err, go IDLE, no push, no run_done.
- Abort:
  - Abort in ISSUE → IDLE next cycle.
  - Abort in WAIT → DRAIN with the timer cleared. DRAIN waits for done_edge (result discarded) or TIMEOUT (sets timeout_err), then goes IDLE.
  - Abort has priority over a same-cycle done_edge in WAIT: the result is not pushed and the block goes IDLE.
  - Abort in IDLE has no effect. Abort never flushes the FIFO; run_done is not pulsed.
- run while busy is ignored.
- FIFO: out_valid = count != 0. A pop occurs when out_valid && out_ready. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH. Output is first-word fall-through; order is strictly by iteration index.
- iter_cnt and index are 16-bit, so a run covers 0 .. n_iter-1 and never wraps.

Test Plan:
1. Config mu=0x00020000, dt=0x00008000, a=0x00100000; run n_iter=4. Core model asserts done 5 cycles after start with x=i·0x10000; out_ready=1. → Exactly 4 core_start pulses; outputs (0,0x0), (1,0x10000), (2,0x20000), (3,0x30000); one run_done; core_mu/dt/a constant; busy=0 afterwards.
2. Backpressure: DEPTH=4, out_ready=0, n_iter=6. → 4 starts, then fifo_count=4 with no 5th start. Raise out_ready → indices 0..5 emerge in order; run_done after 6th push.
3. Timeout: TIMEOUT=32, core never asserts done. → timeout_err=1 exactly 32 cycles after core_start; busy=0; no push; no run_done. Next run clears timeout_err.
4. Abort in WAIT, core done 3 cycles later with x=0x7777. → Nothing pushed; IDLE after drain; no run_done. Abort in IDLE → no state change. Abort coincident with done_edge → no push.
5. n_iter=0 → run_done pulse the next cycle; no core_start; busy stays 0. cfg_we with mu=0x1 during a run → core_mu unchanged.
6. reset=0 for one cycle mid-WAIT with FIFO holding 2 entries → all outputs at reset values, fifo_count=0, state IDLE.
